// File: rtl/data_mem.sv
// Word-organised data memory for the MIPS MEM stage: synchronous write,
// combinational gated read, fixed data-segment window with out-of-window flag.
module data_mem #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0010_0000,
  parameter logic [31:0] INIT_VAL  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Addr,
  input  logic [31:0] Wdata,
  output logic [31:0] Rdata,
  output logic        addr_err
);

  // DEPTH is a power of two (>= 2), so an IDX_W-bit index can never leave the array.
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

  logic [31:0]      mem [DEPTH];
  logic [31:0]      offset;
  logic [IDX_W-1:0] index;
  logic             above_base;
  logic             below_top;
  logic             in_range;
  logic             unused_offset;

  assign offset = Addr - BASE_ADDR;
  assign index  = offset[IDX_W+1:2];

  // Upper bound is checked in 33 bits so a window near 4 GiB cannot wrap.
  assign above_base = (Addr >= BASE_ADDR);
  assign below_top  = ({1'b0, Addr} < ({1'b0, BASE_ADDR} + SPAN));
  assign in_range   = above_base & below_top;

  assign unused_offset = ^{offset[31:IDX_W+2], offset[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= INIT_VAL;
      end
    end else if (MemWrite && in_range) begin
      mem[index] <= Wdata;
    end
  end

  assign Rdata    = (MemRead && in_range) ? mem[index] : 32'h0000_0000;
  assign addr_err = (MemRead | MemWrite) & ~in_range;

endmodule

// File: tb/tb_data_mem.sv
// Directed-vector bench for data_mem; stimulus queues expected read results,
// a separate monitor pops and compares them when a sample is announced.
module tb_data_mem;

  localparam int unsigned DEPTH     = 256;
  localparam logic [31:0] BASE_ADDR = 32'h0010_0000;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic        MemWrite = 1'b0;
  logic        MemRead  = 1'b0;
  logic [31:0] Addr     = 32'h0;
  logic [31:0] Wdata    = 32'h0;
  logic [31:0] Rdata;
  logic        addr_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  event sample_ev;

  always #5 clk = ~clk;

  data_mem #(
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE_ADDR),
    .INIT_VAL (32'h0000_0000)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .MemWrite(MemWrite),
    .MemRead (MemRead),
    .Addr    (Addr),
    .Wdata   (Wdata),
    .Rdata   (Rdata),
    .addr_err(addr_err)
  );

  task automatic drive(input logic [31:0] a, input logic rd, input logic wr,
                       input logic [31:0] wd);
    Addr     = a;
    MemRead  = rd;
    MemWrite = wr;
    Wdata    = wd;
  endtask

  task automatic expect_now(input string name, input logic [31:0] er, input logic ee);
    exp_t e;
    e.rdata = er;
    e.err   = ee;
    e.name  = name;
    sb.push_back(e);
    #1;
    -> sample_ev;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] a, input logic rd,
                     input logic [31:0] er, input logic ee);
    @(negedge clk);
    drive(a, rd, 1'b0, Wdata);
    expect_now(name, er, ee);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    drive(a, 1'b0, 1'b1, wd);
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  // Monitor: compares the DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: sample with no expectation, Rdata=%08h addr_err=%0b",
                 Rdata, addr_err);
      end else begin
        e = sb.pop_front();
        if (Rdata !== e.rdata || addr_err !== e.err) begin
          n_fail++;
          $display("FAIL %s: got Rdata=%08h addr_err=%0b, expected Rdata=%08h addr_err=%0b",
                   e.name, Rdata, addr_err, e.rdata, e.err);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, observed while rst_n is still low
    #1 rst_n = 1'b0;
    #3;
    drive(32'h0010_0001, 1'b0, 1'b0, 32'h0);
    expect_now("rst_read_off", 32'h0, 1'b0);
    MemRead = 1'b1;
    expect_now("rst_read_on", 32'h0, 1'b0);
    drive(32'h0000_0000, 1'b1, 1'b0, 32'h0);
    expect_now("rst_oor_flag", 32'h0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    chk("read_after_reset", 32'h0010_0001, 1'b1, 32'h0, 1'b0);

    // Unaligned write maps to the containing word
    do_write(32'h0010_0001, 32'h0000_000F);
    chk("rd_unaligned",  32'h0010_0001, 1'b1, 32'h0000_000F, 1'b0);
    chk("rd_aligned",    32'h0010_0000, 1'b1, 32'h0000_000F, 1'b0);
    chk("rd_next_word",  32'h0010_0004, 1'b1, 32'h0000_0000, 1'b0);
    chk("rd_gated_off",  32'h0010_0000, 1'b0, 32'h0000_0000, 1'b0);

    // Simultaneous read and write: old value before the edge, new after
    @(negedge clk);
    drive(32'h0010_0008, 1'b1, 1'b1, 32'hDEAD_BEEF);
    expect_now("rw_before_edge", 32'h0, 1'b0);
    @(posedge clk);
    expect_now("rw_after_edge", 32'hDEAD_BEEF, 1'b0);
    MemWrite = 1'b0;

    // Out-of-window accesses
    @(negedge clk);
    drive(32'h0000_0000, 1'b0, 1'b1, 32'h1234_5678);
    expect_now("oor_write_flag", 32'h0, 1'b1);
    @(posedge clk);
    #1 MemWrite = 1'b0;
    chk("oor_wr_word0_kept", 32'h0010_0000, 1'b1, 32'h0000_000F, 1'b0);
    chk("oor_wr_word2_kept", 32'h0010_0008, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("oor_read_top",      BASE_ADDR + 32'(4 * DEPTH), 1'b1, 32'h0, 1'b1);
    chk("oor_read_below",    32'h000F_FFFC, 1'b1, 32'h0, 1'b1);
    chk("oor_read_max",      32'hFFFF_FFFC, 1'b1, 32'h0, 1'b1);
    chk("oor_idle_no_flag",  BASE_ADDR + 32'(4 * DEPTH), 1'b0, 32'h0, 1'b0);

    // Last valid word
    do_write(BASE_ADDR + 32'(4 * (DEPTH - 1)), 32'hCAFE_F00D);
    chk("last_word_read",  BASE_ADDR + 32'(4 * (DEPTH - 1)) + 32'd3, 1'b1, 32'hCAFE_F00D, 1'b0);
    chk("last_no_alias",   32'h0010_0000, 1'b1, 32'h0000_000F, 1'b0);

    // Asynchronous reset pulse between clock edges
    do_write(32'h0010_0010, 32'hA5A5_A5A5);
    chk("pre_pulse_read", 32'h0010_0010, 1'b1, 32'hA5A5_A5A5, 1'b0);
    @(negedge clk);
    drive(32'h0010_0010, 1'b1, 1'b0, 32'h0);
    #1 rst_n = 1'b0;
    expect_now("pulse_during_rst", 32'h0, 1'b0);
    rst_n = 1'b1;
    expect_now("pulse_after_rst", 32'h0, 1'b0);
    chk("pulse_word0_clear", 32'h0010_0000, 1'b1, 32'h0, 1'b0);
    chk("pulse_last_clear",  BASE_ADDR + 32'(4 * (DEPTH - 1)), 1'b1, 32'h0, 1'b0);

    // Write attempted with reset held across a clock edge
    @(negedge clk);
    rst_n = 1'b0;
    drive(32'h0010_0014, 1'b0, 1'b1, 32'h1111_2222);
    @(posedge clk);
    @(negedge clk);
    MemWrite = 1'b0;
    rst_n    = 1'b1;
    MemRead  = 1'b1;
    expect_now("write_in_reset_lost", 32'h0, 1'b0);

    // Normal write still works after that
    do_write(32'h0010_0014, 32'h3333_4444);
    chk("write_after_reset", 32'h0010_0014, 1'b1, 32'h3333_4444, 1'b0);

    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Word-organised data memory for the pipelined MIPS CPU's MEM stage.
- Writes are synchronous on the rising clock edge. Reads are combinational and gated by MemRead.
- Serves a fixed data-segment window starting at BASE_ADDR. Accesses outside the window are flagged and have no effect.

Parameters:
- DEPTH, 256, number of 32-bit words; must be a power of two.
- BASE_ADDR, 32'h0010_0000, byte address of word 0.
- INIT_VAL, 32'h0000_0000, value every word takes on reset.

Ports:
- clk  in  1  system clock; rising edge active.
- rst_n  in  1  asynchronous, active-low reset.
- MemWrite  in  1  write enable.
- MemRead  in  1  read enable.
- Addr  in  32  byte address.
- Wdata  in  32  write data.
- Rdata  out  32  read data.
- addr_err  out  1  access to an address outside the window.

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Storage: DEPTH x 32-bit array.
- Word index = (Addr - BASE_ADDR) >> 2, computed with 32-bit unsigned subtraction. Addr[1:0] is ignored, so unaligned addresses map to the containing word (0x00100001 -> word 0).
- In range when BASE_ADDR <= Addr < BASE_ADDR + 4*DEPTH. The upper bound is compared without overflow wrap, using 33-bit arithmetic.
- Reset (rst_n=0): immediate and asynchronous.
  - Every word is set to INIT_VAL.
  - Rdata shows only the combinational read; no registered state remains.
  - Writes are blocked while rst_n=0.
  - Reset asserted during a write cycle: the write is lost and the word holds INIT_VAL.
- Write:
  - On posedge clk, with rst_n=1, MemWrite=1 and the address in range, mem[index] <= Wdata.
  - Out-of-range writes change no word.
- Read:
  - Combinational, zero latency.
  - Rdata = mem[index] when MemRead=1 and the address is in range; otherwise Rdata = 32'h0.
  - Rdata follows Addr and memory changes within the same cycle.
- Simultaneous MemRead=1 and MemWrite=1 to the same word: before the edge, Rdata shows the old value; after the edge, it shows Wdata. There is no forwarding.
- addr_err = (MemRead | MemWrite) & ~in_range, purely combinational. It is 0 when neither enable is set and 0 during reset for in-range addresses.
- Rdata and addr_err are never X after reset. Indices are always bounded, so no X-propagation can come from out-of-range indexing.
- No other side effects. The memory retains contents indefinitely between writes.

Test Plan:
1. Reset, then MemRead=0, Addr=0x00100001 -> Rdata=0x00000000, addr_err=0. Set MemRead=1 -> Rdata=0x00000000.
2. Write Addr=0x00100001, Wdata=0x0000000F, MemWrite=1, one clock edge. Then MemRead=1, MemWrite=0:
   - Rdata=0x0000000F at Addr 0x00100001.
   - Rdata=0x0000000F at Addr 0x00100000 (same word).
   - Rdata=0x00000000 at Addr 0x00100004.
3. MemRead=MemWrite=1 at Addr 0x00100008, Wdata=0xDEADBEEF, old value 0 -> Rdata=0 before posedge, 0xDEADBEEF after.
4. Out-of-range access:
   - Addr=0x00000000 with MemWrite=1, Wdata=0x12345678, clock edge -> addr_err=1, no word changed.
   - Read of Addr 0x00100000 + 4*DEPTH -> Rdata=0, addr_err=1.
   - Last valid word, 0x00100000 + 4*(DEPTH-1), is writable and readable with addr_err=0.
5. Write 0xA5A5A5A5 to 0x00100010, then pulse rst_n=0 asynchronously mid-cycle (no clock edge) -> reading 0x00100010 returns 0x00000000 immediately after release.
6. MemWrite=1 with rst_n held low across a clock edge -> the word stays INIT_VAL after reset release.
